// File: rtl/manch_rx_ctrl_if.sv
// Decoder-side and consumer-side signals of the Manchester frame receiver.
// parity_err exists only when MANCH_RX_PARITY_EN is defined.
interface manch_rx_ctrl_if #(parameter int DATAWIDTH = 8);
  logic                 line_in;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 dec_enable;
  logic                 dec_clear;
  logic [DATAWIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef MANCH_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  line_in, bit_in, bit_valid, data_ready,
`ifdef MANCH_RX_PARITY_EN
    output parity_err,
`endif
    output dec_enable, dec_clear, data_out, data_valid, frame_err, overrun, busy
  );

  modport slave (
    output line_in, bit_in, bit_valid, data_ready,
`ifdef MANCH_RX_PARITY_EN
    input  parity_err,
`endif
    input  dec_enable, dec_clear, data_out, data_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/manch_rx_ctrl.sv
// Frame-level receive controller: start/data/stop framing, timeout, output register.
// Optional even-parity bit enabled by defining MANCH_RX_PARITY_EN.
module manch_rx_ctrl #(
  parameter int DATAWIDTH   = 8,
  parameter int TIMEOUT_CYC = 60,
  parameter int CNT_W       = 6
) (
  input  logic            clk_20x,
  input  logic            rst_n,
  manch_rx_ctrl_if.master bus
);
  localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA,
`ifdef MANCH_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 line_q, line_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATAWIDTH-1:0] sr_q, sr_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 clr_q, clr_d;
  logic                 en_q, en_d;
  logic                 in_frame;
`ifdef MANCH_RX_PARITY_EN
  logic                 pe_q, pe_d;
`endif

  always_ff @(posedge clk_20x) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= 1'b0;
      tmo_q   <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
`ifdef MANCH_RX_PARITY_EN
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      tmo_q   <= tmo_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
`ifdef MANCH_RX_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = bus.line_in;
    tmo_d    = tmo_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    fe_d     = 1'b0;
    ovr_d    = ovr_q;
`ifdef MANCH_RX_PARITY_EN
    pe_d     = 1'b0;
    in_frame = state_q inside {S_START, S_DATA, S_PARITY, S_STOP};
`else
    in_frame = state_q inside {S_START, S_DATA, S_STOP};
`endif
    // Decoder controls lag the state by one cycle so clear precedes enable.
    clr_d    = (state_q == S_ARM);
    en_d     = in_frame;

    if (dv_q && bus.data_ready) dv_d = 1'b0;

    if (in_frame) begin
      if (bus.bit_valid) tmo_d = '0;
      else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        fe_d    = 1'b1;
        state_d = S_IDLE;
      end else tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE:  if (bus.line_in && !line_q) state_d = S_ARM;
      S_ARM: begin
        state_d = S_START;
        tmo_d   = '0;
      end
      S_START: if (bus.bit_valid) begin
        if (bus.bit_in) begin
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (bus.bit_valid) begin
        sr_d = {bus.bit_in, sr_q[DATAWIDTH-1:1]};
        if (bcnt_q == BW'(DATAWIDTH - 1)) begin
`ifdef MANCH_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else bcnt_d = bcnt_q + 1'b1;
      end
`ifdef MANCH_RX_PARITY_EN
      S_PARITY: if (bus.bit_valid) begin
        pe_d    = (bus.bit_in != ^sr_q);
        state_d = S_STOP;
      end
`endif
      S_STOP: if (bus.bit_valid) begin
        state_d = S_IDLE;
        if (!bus.bit_in) fe_d = 1'b1;
        else if (!dv_q || bus.data_ready) begin
          dout_d = sr_q;
          dv_d   = 1'b1;
        end else ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dec_enable = en_q;
  assign bus.dec_clear  = clr_q;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != S_IDLE);
`ifdef MANCH_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`endif
endmodule

// File: tb/tb_manch_rx_ctrl.sv
// Directed bench for manch_rx_ctrl: framing, timeout, output handshake, overrun, reset.
module tb_manch_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  manch_rx_ctrl_if #(.DATAWIDTH(8)) ifc ();

  manch_rx_ctrl #(.DATAWIDTH(8), .TIMEOUT_CYC(60), .CNT_W(6)) dut (
    .clk_20x (clk),
    .rst_n   (rst_n),
    .bus     (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    @(negedge clk);
    ifc.bit_in    = b;
    ifc.bit_valid = 1'b1;
    @(negedge clk);
    ifc.bit_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_edge();
    @(negedge clk);
    ifc.line_in = 1'b1;
    @(negedge clk);
    ifc.line_in = 1'b0;
    gap(2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    start_edge();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      gap(2);
      send_bit(d[i]);
    end
`ifdef MANCH_RX_PARITY_EN
    gap(2);
    send_bit(^d);
`endif
    gap(2);
    send_bit(stopb);
  endtask

  task automatic test_reset();
    ifc.line_in = 0; ifc.bit_in = 0; ifc.bit_valid = 0; ifc.data_ready = 0;
    rst_n = 1'b0;
    gap(3);
    total++;
    if ({ifc.dec_enable, ifc.dec_clear, ifc.data_valid, ifc.frame_err, ifc.overrun, ifc.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
        {ifc.dec_enable, ifc.dec_clear, ifc.data_valid, ifc.frame_err, ifc.overrun, ifc.busy});
    end
    total++;
    if (ifc.data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", ifc.data_out); end
    rst_n = 1'b1;
    send_bit(1'b1);
    gap(1);
    total++;
    if (ifc.busy !== 1'b0 || ifc.frame_err !== 1'b0) begin
      bad++; $display("FAIL idle_strobe_ignored: busy=%b fe=%b want 0 0", ifc.busy, ifc.frame_err);
    end
  endtask

  task automatic test_arm_timing();
    @(negedge clk);
    ifc.line_in = 1'b1;
    @(negedge clk);
    ifc.line_in = 1'b0;
    total++;
    if (ifc.busy !== 1'b1 || ifc.dec_clear !== 1'b0) begin
      bad++; $display("FAIL arm_entry: busy=%b clr=%b want 1 0", ifc.busy, ifc.dec_clear);
    end
    @(negedge clk);
    total++;
    if (ifc.dec_clear !== 1'b1 || ifc.dec_enable !== 1'b0) begin
      bad++; $display("FAIL dec_clear: clr=%b en=%b want 1 0", ifc.dec_clear, ifc.dec_enable);
    end
    @(negedge clk);
    total++;
    if (ifc.dec_clear !== 1'b0 || ifc.dec_enable !== 1'b1) begin
      bad++; $display("FAIL dec_enable: clr=%b en=%b want 0 1", ifc.dec_clear, ifc.dec_enable);
    end
    gap(70);  // let the armed frame time out before the next test
    total++;
    if (ifc.busy !== 1'b0) begin bad++; $display("FAIL arm_timeout_idle: busy=%b want 0", ifc.busy); end
  endtask

  task automatic test_clean_frame();
    ifc.data_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    total++;
    if (ifc.data_valid !== 1'b1 || ifc.data_out !== 8'hA5) begin
      bad++; $display("FAIL clean_data: dv=%b data=%h want 1 a5", ifc.data_valid, ifc.data_out);
    end
    total++;
    if (ifc.frame_err !== 1'b0 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL clean_flags: fe=%b busy=%b want 0 0", ifc.frame_err, ifc.busy);
    end
    @(negedge clk);
    total++;
    if (ifc.data_valid !== 1'b0 || ifc.dec_enable !== 1'b0) begin
      bad++; $display("FAIL clean_after: dv=%b en=%b want 0 0", ifc.data_valid, ifc.dec_enable);
    end
  endtask

  task automatic test_bad_start();
    start_edge();
    send_bit(1'b1);
    total++;
    if (ifc.frame_err !== 1'b1 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL bad_start_err: fe=%b busy=%b want 1 0", ifc.frame_err, ifc.busy);
    end
    @(negedge clk);
    total++;
    if (ifc.frame_err !== 1'b0 || ifc.dec_enable !== 1'b0 || ifc.data_valid !== 1'b0) begin
      bad++; $display("FAIL bad_start_after: fe=%b en=%b dv=%b want 0 0 0",
        ifc.frame_err, ifc.dec_enable, ifc.data_valid);
    end
  endtask

  task automatic test_bad_stop();
    send_frame(8'h3C, 1'b0);
    total++;
    if (ifc.frame_err !== 1'b1 || ifc.data_valid !== 1'b0) begin
      bad++; $display("FAIL bad_stop: fe=%b dv=%b want 1 0", ifc.frame_err, ifc.data_valid);
    end
    @(negedge clk);
    total++;
    if (ifc.frame_err !== 1'b0) begin bad++; $display("FAIL bad_stop_pulse: fe=%b want 0", ifc.frame_err); end
  endtask

  task automatic test_timeout();
    int k;
    k = 0;
    start_edge();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) begin
      gap(2);
      send_bit(1'b1);
    end
    for (int j = 1; j <= 100 && k == 0; j++) begin
      @(negedge clk);
      if (ifc.frame_err === 1'b1) k = j;
    end
    total++;
    if (k != 60) begin bad++; $display("FAIL timeout_cycles: got %0d want 60", k); end
    total++;
    if (ifc.busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy=%b want 0", ifc.busy); end
  endtask

  task automatic test_overrun();
    ifc.data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    total++;
    if (ifc.data_valid !== 1'b1 || ifc.data_out !== 8'h11 || ifc.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_first: dv=%b data=%h ovr=%b want 1 11 0",
        ifc.data_valid, ifc.data_out, ifc.overrun);
    end
    send_frame(8'h22, 1'b1);
    total++;
    if (ifc.data_valid !== 1'b1 || ifc.data_out !== 8'h11 || ifc.overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_second: dv=%b data=%h ovr=%b want 1 11 1",
        ifc.data_valid, ifc.data_out, ifc.overrun);
    end
    ifc.data_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.data_valid !== 1'b0 || ifc.overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_accept: dv=%b ovr=%b want 0 1", ifc.data_valid, ifc.overrun);
    end
  endtask

  task automatic test_back_to_back();
    ifc.data_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    total++;
    if (ifc.data_out !== 8'h5A || ifc.data_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first: data=%h dv=%b want 5a 1", ifc.data_out, ifc.data_valid);
    end
    send_frame(8'hC3, 1'b1);
    total++;
    if (ifc.data_out !== 8'hC3 || ifc.data_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_second: data=%h dv=%b want c3 1", ifc.data_out, ifc.data_valid);
    end
  endtask

`ifdef MANCH_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'h07;
    ifc.data_ready = 1'b1;
    start_edge();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      gap(2);
      send_bit(d[i]);
    end
    gap(2);
    send_bit(1'b0);
    total++;
    if (ifc.parity_err !== 1'b1) begin bad++; $display("FAIL parity_err: got %b want 1", ifc.parity_err); end
    gap(2);
    send_bit(1'b1);
    total++;
    if (ifc.data_out !== 8'h07 || ifc.data_valid !== 1'b1 || ifc.parity_err !== 1'b0) begin
      bad++; $display("FAIL parity_data: data=%h dv=%b pe=%b want 07 1 0",
        ifc.data_out, ifc.data_valid, ifc.parity_err);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    ifc.data_ready = 1'b0;
    start_edge();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      gap(2);
      send_bit(1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.dec_enable, ifc.dec_clear, ifc.data_valid, ifc.frame_err, ifc.overrun, ifc.busy} !== 6'b0
        || ifc.data_out !== 8'h00) begin
      bad++; $display("FAIL mid_reset: flags=%b data=%h want 000000 00",
        {ifc.dec_enable, ifc.dec_clear, ifc.data_valid, ifc.frame_err, ifc.overrun, ifc.busy}, ifc.data_out);
    end
    rst_n = 1'b1;
    gap(2);
    total++;
    if (ifc.frame_err !== 1'b0 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_after: fe=%b busy=%b want 0 0", ifc.frame_err, ifc.busy);
    end
  endtask

  initial begin
    test_reset();
    test_arm_timing();
    test_clean_frame();
    test_bad_start();
    test_bad_stop();
    test_timeout();
    test_overrun();
    test_back_to_back();
`ifdef MANCH_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/manch_rx_ctrl.md
# manch_rx_ctrl

Frame-level receive controller for the Manchester decoder path. It watches the line for activity, then clears and enables the bit decoder. It collects the decoder's bit strobes into start/data/stop frames, checks framing and timeouts, and presents each completed word on a valid/ready output register. It sits between the Manchester bit decoder and the UART/host-side consumer, on the same 20x oversample clock.

## Interface
- `DATAWIDTH`, 8, data bits per frame, LSB first
- `TIMEOUT_CYC`, 60, max clk_20x cycles allowed between bit strobes inside a frame (3 bit periods)
- `CNT_W`, 6, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC
- `clk_20x`  in  1  20x-oversample clock
- `rst_n`  in  1  synchronous reset, active low
- `line_in`  in  1  Manchester line, already synchronous to clk_20x
- `bit_in`  in  1  decoded bit from decoder
- `bit_valid`  in  1  one-cycle strobe; bit_in is valid in that cycle
- `dec_enable`  out  1  enables decoder sampling
- `dec_clear`  out  1  one-cycle decoder phase/counter clear
- `data_out`  out  DATAWIDTH  received word
- `data_valid`  out  1  data_out holds an unconsumed word
- `data_ready`  in  1  consumer accepts the word when data_valid && data_ready
- `frame_err`  out  1  one-cycle pulse: bad start, bad stop or timeout
- `overrun`  out  1  sticky; set when a word is dropped, cleared by reset only
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ARM, START, DATA, [PARITY], STOP.
- IDLE: `line_q` registers `line_in`. On a rising edge (`line_in && !line_q`), go to ARM.
- ARM: hold one cycle with dec_clear=1 and dec_enable=0, then go to START.
- dec_enable=1 in START, DATA, PARITY and STOP. It is 0 in IDLE and ARM.
- START: the first bit_valid must carry bit_in=0. A 0 goes to DATA with the bit counter reset to 0. A 1 pulses frame_err and returns to IDLE.
- DATA: each bit_valid shifts bit_in into the shift register MSB (right shift, so LSB first). The bit counter increments. After DATAWIDTH bits, go to PARITY if MANCH_RX_PARITY_EN is defined, else STOP.
- STOP: bit_in=1 completes the frame and returns to IDLE. bit_in=0 pulses frame_err, discards the word and returns to IDLE.
- Timeout: the counter resets on every bit_valid and on entry to START. It increments each cycle in START/DATA/PARITY/STOP. When it reaches TIMEOUT_CYC-1 with no strobe: pulse frame_err and return to IDLE.
- Word completion: if data_valid=0, or if data_ready=1 in the same cycle, load data_out and set data_valid=1. Otherwise keep the old data_out and data_valid, set overrun and drop the new word.
- data_valid clears on the handshake cycle unless a new word loads in that same cycle.
- Reset values: state=IDLE; dec_enable, dec_clear, data_valid, frame_err, overrun and busy all 0; data_out all zeros. Counters and shift register are cleared.
- Reset mid-frame abandons the frame with no frame_err pulse.
- A bit_valid arriving in IDLE or ARM is ignored.

## Timing
- dec_clear asserts the cycle after the rising edge is seen in line_q, i.e. 2 cycles after line_in rises.
- dec_enable asserts 1 cycle after dec_clear.
- data_valid rises the cycle after the stop-bit bit_valid.
- frame_err is registered and rises the cycle after the offending strobe or the timeout expiry.
- data_out is stable while data_valid=1 and data_ready=0.
- Back-to-back frames: the controller is in IDLE 1 cycle after the stop bit and can detect the next start edge immediately.

## Configuration
- `MANCH_RX_PARITY_EN` defined:
  - PARITY state is present. One even-parity bit follows the data.
  - Adds output `parity_err` (1-bit, registered one-cycle pulse).
  - On mismatch, parity_err pulses and the word is still delivered; the frame continues to STOP.
- Undefined: no PARITY state, no parity_err port, and the frame is start + DATAWIDTH + stop.

## Test plan
- Clean frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), data_ready=1 → data_out=0xA5, data_valid high for 1 cycle, frame_err=0, busy low afterwards.
- Start bit 1 → frame_err pulses once, dec_enable drops, state IDLE, data_valid stays 0.
- Stop bit 0 after data 0x3C → frame_err pulse, data_valid stays 0.
- bit_valid stops after 4 data bits → frame_err exactly TIMEOUT_CYC cycles after the last strobe, return to IDLE.
- Two frames 0x11 then 0x22 with data_ready=0 → data_out stays 0x11 and overrun=1. Then raise data_ready → 0x11 is accepted and data_valid falls.
- With MANCH_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err pulses and data_out=0x07. Assert rst_n=0 mid-DATA → all outputs return to reset values.
